// File: rtl/uart_pkg.sv
// Shared UART definitions: one-hot receiver states, default line settings,
// and the baud divisor helper used by both directions.
package uart_pkg;

  typedef enum logic [4:0] {
    S_IDLE       = 5'b00001,
    S_START_BIT  = 5'b00010,
    S_DATA_BITS  = 5'b00100,
    S_PARITY_BIT = 5'b01000,
    S_STOP_BIT   = 5'b10000
  } state_t;

  localparam int unsigned DEF_CLOCK_FREQ = 100_000_000;
  localparam int unsigned DEF_BAUD_RATE  = 9600;
  localparam int unsigned OVERSAMPLE     = 16;

  function automatic int unsigned baud_div(input int unsigned clk_hz,
                                           input int unsigned baud,
                                           input int unsigned os);
    return clk_hz / (baud * os);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle tick every DIV clocks. Clear restarts
// the phase so sampling can be aligned to a detected line edge.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int unsigned DIV = baud_div(DEF_CLOCK_FREQ, DEF_BAUD_RATE, OVERSAMPLE)
) (
  input  logic clk,
  input  logic reset_p,
  input  logic clear,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] r_cnt;

  assign tick = (r_cnt == CW'(DIV - 1));

  always_ff @(posedge clk) begin
    if (reset_p || clear || tick) r_cnt <= '0;
    else                          r_cnt <= r_cnt + 1'b1;
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8 data bits LSB first, 16x oversampled, one stop bit.
// Define UART_RX_PARITY_EN to expect one even-parity bit after the data.
module uart_rx #(
  parameter int unsigned CLOCK_FREQ = uart_pkg::DEF_CLOCK_FREQ,
  parameter int unsigned BAUD_RATE  = uart_pkg::DEF_BAUD_RATE,
  parameter int unsigned OVERSAMPLE = uart_pkg::OVERSAMPLE
) (
  input  logic        clk,
  input  logic        reset_p,
  input  logic        Rx,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        frame_err,
  output logic        parity_err,
  output logic        busy,
  output logic [15:0] led_debug
);
  import uart_pkg::*;

  localparam int unsigned DIV      = baud_div(CLOCK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam logic [3:0]  SUB_MID  = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0]  SUB_LAST = 4'(OVERSAMPLE - 1);

  state_t     r_state, w_next;
  logic       r_rx_meta, r_rx_s, r_rx_prev;
  logic [3:0] r_sub;
  logic [2:0] r_bit;
  logic [7:0] r_shift, r_data;
  logic       r_valid, r_ferr;
  logic       w_fall, w_start, w_tick, w_mid, w_last;

  assign w_fall  = r_rx_prev & ~r_rx_s;
  assign w_start = (r_state == S_IDLE) & w_fall;
  assign w_mid   = w_tick & (r_sub == SUB_MID);
  assign w_last  = w_tick & (r_sub == SUB_LAST);

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk     (clk),
    .reset_p (reset_p),
    .clear   (w_start),
    .tick    (w_tick)
  );

  always_ff @(posedge clk) begin
    if (reset_p) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:       if (w_fall) w_next = S_START_BIT;
      S_START_BIT:  if (w_mid)  w_next = r_rx_s ? S_IDLE : S_DATA_BITS;
      S_DATA_BITS:  if (w_last && r_bit == 3'd7)
`ifdef UART_RX_PARITY_EN
                      w_next = S_PARITY_BIT;
`else
                      w_next = S_STOP_BIT;
`endif
      S_PARITY_BIT: if (w_last) w_next = S_STOP_BIT;
      S_STOP_BIT:   if (w_last) w_next = S_IDLE;
      default:      w_next = S_IDLE;
    endcase
  end

`ifdef UART_RX_PARITY_EN
  logic r_perr, r_par_bad;
`endif

  always_ff @(posedge clk) begin
    if (reset_p) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
      r_rx_prev <= 1'b1;
      r_sub     <= '0;
      r_bit     <= '0;
      r_shift   <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_ferr    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_perr    <= 1'b0;
      r_par_bad <= 1'b0;
`endif
    end else begin
      r_rx_meta <= Rx;
      r_rx_s    <= r_rx_meta;
      r_rx_prev <= r_rx_s;
      r_valid   <= 1'b0;
      r_ferr    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_perr    <= 1'b0;
`endif
      // Sub-bit phase restarts at the start edge and again at mid-start-bit,
      // so every later sample lands in the middle of its bit.
      if (r_state == S_IDLE || (r_state == S_START_BIT && w_mid)) r_sub <= '0;
      else if (w_tick)                                            r_sub <= r_sub + 1'b1;

      case (r_state)
        S_START_BIT: r_bit <= '0;
        S_DATA_BITS: if (w_last) begin
          r_shift <= {r_rx_s, r_shift[7:1]};
          r_bit   <= r_bit + 1'b1;
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY_BIT: if (w_last) r_par_bad <= ^{r_shift, r_rx_s};
`endif
        S_STOP_BIT: if (w_last) begin
          if (!r_rx_s) r_ferr <= 1'b1;
`ifdef UART_RX_PARITY_EN
          else if (r_par_bad) r_perr <= 1'b1;
`endif
          else begin
            r_data  <= r_shift;
            r_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef UART_RX_PARITY_EN
  assign parity_err = r_perr;
`else
  assign parity_err = 1'b0;
`endif

  assign rx_data   = r_data;
  assign rx_valid  = r_valid;
  assign frame_err = r_ferr;
  assign busy      = (r_state != S_IDLE);
  assign led_debug = {r_data, 2'b00, r_rx_s, r_state};

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at DIV=10 (160 clk per bit); the parity
// scenario is included when UART_RX_PARITY_EN is defined.
module tb_uart_rx;
  localparam int BIT = 160;

  logic        clk = 1'b0;
  logic        reset_p = 1'b1;
  logic        Rx = 1'b1;
  logic [7:0]  rx_data;
  logic        rx_valid, frame_err, parity_err, busy;
  logic [15:0] led_debug;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int n_valid = 0, n_ferr = 0, n_perr = 0;
  int last_vcyc = 0, prev_vcyc = 0;
  logic [7:0] last_vdata = '0, prev_vdata = '0;
  int t_start = 0;

  uart_rx #(.CLOCK_FREQ(1600000), .BAUD_RATE(10000), .OVERSAMPLE(16)) dut (
    .clk        (clk),
    .reset_p    (reset_p),
    .Rx         (Rx),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .busy       (busy),
    .led_debug  (led_debug)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_valid) begin
      n_valid++;
      prev_vcyc  = last_vcyc;
      last_vcyc  = cyc;
      prev_vdata = last_vdata;
      last_vdata = rx_data;
    end
    if (frame_err)  n_ferr++;
    if (parity_err) n_perr++;
  end

  task automatic drive_bit(input logic b);
    Rx = b;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic idle(input int n);
    Rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
    t_start = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(par);
`else
    if (par !== 1'bx) ; // parity bit not sent in 8N1 build
`endif
    drive_bit(stop);
  endtask

  task automatic test_reset;
    reset_p = 1'b1;
    repeat (4) @(negedge clk);
    tests++; if (rx_data !== 8'h00)      begin fails++; $display("FAIL reset_data got %h exp 00", rx_data); end
    tests++; if (rx_valid !== 1'b0)      begin fails++; $display("FAIL reset_valid got %b exp 0", rx_valid); end
    tests++; if (frame_err !== 1'b0)     begin fails++; $display("FAIL reset_ferr got %b exp 0", frame_err); end
    tests++; if (parity_err !== 1'b0)    begin fails++; $display("FAIL reset_perr got %b exp 0", parity_err); end
    tests++; if (busy !== 1'b0)          begin fails++; $display("FAIL reset_busy got %b exp 0", busy); end
    tests++; if (led_debug !== 16'h0021) begin fails++; $display("FAIL reset_led got %h exp 0021", led_debug); end
    reset_p = 1'b0;
    idle(20);
  endtask

  task automatic test_basic;
    int v0, f0, d;
    v0 = n_valid; f0 = n_ferr;
    send_frame(8'hA5, ^8'hA5, 1'b1);
    idle(40);
    d = last_vcyc - t_start;
    tests++; if (n_valid - v0 !== 1) begin fails++; $display("FAIL basic_pulses got %0d exp 1", n_valid - v0); end
    tests++; if (rx_data !== 8'hA5)  begin fails++; $display("FAIL basic_data got %h exp a5", rx_data); end
    tests++; if (n_ferr - f0 !== 0)  begin fails++; $display("FAIL basic_ferr got %0d exp 0", n_ferr - f0); end
    tests++; if (d < 1521 || d > 1525) begin fails++; $display("FAIL basic_latency got %0d exp 1521..1525", d); end
    tests++; if (led_debug !== 16'hA521) begin fails++; $display("FAIL basic_led got %h exp a521", led_debug); end
  endtask

  task automatic test_glitch;
    int v0, f0, p0;
    v0 = n_valid; f0 = n_ferr; p0 = n_perr;
    Rx = 1'b0;
    repeat (20) @(negedge clk);
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL glitch_busy_hi got %b exp 1", busy); end
    repeat (20) @(negedge clk);
    idle(100);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL glitch_busy_lo got %b exp 0", busy); end
    tests++; if (led_debug[4:0] !== 5'b00001) begin fails++; $display("FAIL glitch_state got %b exp 00001", led_debug[4:0]); end
    tests++; if ((n_valid - v0) + (n_ferr - f0) + (n_perr - p0) !== 0)
      begin fails++; $display("FAIL glitch_pulses got %0d exp 0", (n_valid - v0) + (n_ferr - f0) + (n_perr - p0)); end
  endtask

  task automatic test_frame_err;
    int v0, f0;
    v0 = n_valid; f0 = n_ferr;
    send_frame(8'hFF, ^8'hFF, 1'b0);
    idle(320);
    tests++; if (n_ferr - f0 !== 1)  begin fails++; $display("FAIL ferr_pulse got %0d exp 1", n_ferr - f0); end
    tests++; if (n_valid - v0 !== 0) begin fails++; $display("FAIL ferr_novalid got %0d exp 0", n_valid - v0); end
    tests++; if (rx_data !== 8'hA5)  begin fails++; $display("FAIL ferr_keep got %h exp a5", rx_data); end
    send_frame(8'h3C, ^8'h3C, 1'b1);
    idle(40);
    tests++; if (n_valid - v0 !== 1) begin fails++; $display("FAIL ferr_next_pulse got %0d exp 1", n_valid - v0); end
    tests++; if (rx_data !== 8'h3C)  begin fails++; $display("FAIL ferr_next_data got %h exp 3c", rx_data); end
  endtask

  task automatic test_back_to_back;
    int v0;
    v0 = n_valid;
    send_frame(8'h00, ^8'h00, 1'b1);
    send_frame(8'hFF, ^8'hFF, 1'b1);
    idle(40);
    tests++; if (n_valid - v0 !== 2) begin fails++; $display("FAIL b2b_pulses got %0d exp 2", n_valid - v0); end
    tests++; if (last_vcyc - prev_vcyc !== 1600) begin fails++; $display("FAIL b2b_gap got %0d exp 1600", last_vcyc - prev_vcyc); end
    tests++; if (prev_vdata !== 8'h00) begin fails++; $display("FAIL b2b_first got %h exp 00", prev_vdata); end
    tests++; if (last_vdata !== 8'hFF) begin fails++; $display("FAIL b2b_second got %h exp ff", last_vdata); end
  endtask

  task automatic test_reset_mid;
    int v0, f0, p0;
    logic [7:0] d;
    d = 8'h55;
    reset_p = 1'b1;
    repeat (3) @(negedge clk);
    reset_p = 1'b0;
    idle(20);
    v0 = n_valid; f0 = n_ferr; p0 = n_perr;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(d[i]);
    Rx = d[4];
    repeat (BIT / 2) @(negedge clk);
    reset_p = 1'b1;
    repeat (3) @(negedge clk);
    reset_p = 1'b0;
    idle(800);
    tests++; if ((n_valid - v0) + (n_ferr - f0) + (n_perr - p0) !== 0)
      begin fails++; $display("FAIL rst_mid_pulses got %0d exp 0", (n_valid - v0) + (n_ferr - f0) + (n_perr - p0)); end
    tests++; if (rx_data !== 8'h00) begin fails++; $display("FAIL rst_mid_data got %h exp 00", rx_data); end
    tests++; if (busy !== 1'b0)     begin fails++; $display("FAIL rst_mid_busy got %b exp 0", busy); end
    send_frame(8'h81, ^8'h81, 1'b1);
    idle(40);
    tests++; if (n_valid - v0 !== 1 || rx_data !== 8'h81)
      begin fails++; $display("FAIL rst_mid_next got %0d/%h exp 1/81", n_valid - v0, rx_data); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity;
    int v0, p0;
    v0 = n_valid; p0 = n_perr;
    send_frame(8'h07, 1'b0, 1'b1);
    idle(40);
    tests++; if (n_perr - p0 !== 1)  begin fails++; $display("FAIL par_bad_perr got %0d exp 1", n_perr - p0); end
    tests++; if (n_valid - v0 !== 0) begin fails++; $display("FAIL par_bad_valid got %0d exp 0", n_valid - v0); end
    send_frame(8'h07, 1'b1, 1'b1);
    idle(40);
    tests++; if (n_valid - v0 !== 1 || rx_data !== 8'h07)
      begin fails++; $display("FAIL par_ok got %0d/%h exp 1/07", n_valid - v0, rx_data); end
    tests++; if (n_perr - p0 !== 1)  begin fails++; $display("FAIL par_ok_perr got %0d exp 1", n_perr - p0); end
  endtask
`endif

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_back_to_back();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
